// File: rtl/fifo_stream_reader.sv
// Read-side adapter for the cross-clock FIFO: drains the fixed-latency read port
// into a valid/ready stream through a skid buffer that covers every in-flight read.
module fifo_stream_reader #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned ADDR_BITS    = 4,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 fifo_rd_en,
    input  logic [WIDTH-1:0]     fifo_rd_data,
    input  logic                 fifo_rd_empty,
    input  logic [ADDR_BITS:0]   fifo_rd_size,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [31:0]          words_sent,
    output logic                 rd_underflow_err
);
    localparam int unsigned SKID_DEPTH = READ_LATENCY + 2;
    localparam int unsigned PTR_W      = $clog2(SKID_DEPTH);
    localparam int unsigned CNT_W      = $clog2(SKID_DEPTH + 1);
    localparam int unsigned SUM_W      = CNT_W + 1;

    logic [READ_LATENCY-1:0] sr_q, sr_d;
    logic [WIDTH-1:0]        mem_q [SKID_DEPTH];
    logic [WIDTH-1:0]        mem_d [SKID_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [31:0]             words_sent_q, words_sent_d;
    logic                    rd_underflow_err_q, rd_underflow_err_d;

    logic [CNT_W-1:0]        inflight_c;
    logic [SUM_W-1:0]        occupancy_c;
    logic                    push_c;
    logic                    pop_c;

    // Occupancy is informational only; flow control uses the empty flag.
    logic unused_size_c;
    assign unused_size_c = ^fifo_rd_size;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Issue only when every outstanding read is guaranteed a buffer slot.
    always_comb begin
        inflight_c = '0;
        for (int i = 0; i < int'(READ_LATENCY); i++) begin
            inflight_c = inflight_c + CNT_W'(sr_q[i]);
        end
        occupancy_c = SUM_W'(inflight_c) + SUM_W'(count_q);
        fifo_rd_en  = !fifo_rd_empty && (occupancy_c < SUM_W'(SKID_DEPTH)) && !reset;
    end

    always_comb begin
        push_c = sr_q[READ_LATENCY-1];
        pop_c  = (count_q != '0) && out_ready;

        sr_d[0] = fifo_rd_en;
        for (int i = 1; i < int'(READ_LATENCY); i++) begin
            sr_d[i] = sr_q[i-1];
        end

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push_c) begin
            mem_d[wr_ptr_q] = fifo_rd_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop_c) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        words_sent_d       = words_sent_q + 32'(pop_c);
        rd_underflow_err_d = rd_underflow_err_q | (fifo_rd_en & fifo_rd_empty);
    end

    // Reset drops the inflight bits, so data from pre-reset reads is never captured.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q               <= '0;
            mem_q              <= '{default: '0};
            wr_ptr_q           <= '0;
            rd_ptr_q           <= '0;
            count_q            <= '0;
            words_sent_q       <= '0;
            rd_underflow_err_q <= 1'b0;
        end else begin
            sr_q               <= sr_d;
            mem_q              <= mem_d;
            wr_ptr_q           <= wr_ptr_d;
            rd_ptr_q           <= rd_ptr_d;
            count_q            <= count_d;
            words_sent_q       <= words_sent_d;
            rd_underflow_err_q <= rd_underflow_err_d;
        end
    end

    assign out_valid        = (count_q != '0);
    assign out_data         = mem_q[rd_ptr_q];
    assign words_sent       = words_sent_q;
    assign rd_underflow_err = rd_underflow_err_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: READ_LATENCY=2 and =1 instances run in lockstep against
// a FIFO model and a word-level reference (order, arrival time, issue rule).
`timescale 1ns/1ps
module tb_fifo_stream_reader;
    localparam int unsigned W   = 16;
    localparam int unsigned AB  = 4;
    localparam int unsigned SW  = AB + 1;
    localparam int          NWR = 2048;

    logic            clk = 1'b0;
    logic            reset;
    logic            out_ready;
    logic [1:0]      rd_en;
    logic [1:0]      rd_empty;
    logic [1:0]      out_valid;
    logic [1:0]      err;
    logic [W-1:0]    rd_data  [2];
    logic [SW-1:0]   rd_size  [2];
    logic [W-1:0]    out_data [2];
    logic [31:0]     ws       [2];

    always #5 clk = ~clk;

    // FIFO model: shared write history, one read index and data pipe per instance
    logic [W-1:0] wr_words [NWR];
    int           wr_cnt;
    int           rd_idx [2];
    logic [W-1:0] pipe [2][2];

    // Reference: every word read, with the cycle it must first be presentable
    logic [W-1:0] exp_dat [2][NWR];
    int           exp_av  [2][NWR];
    int           head [2];
    int           tail [2];
    int           sent [2];
    int           cyc;

    int n_pass, n_total;
    int nrden [2], first_rden [2], last_rden [2];
    int nvalid [2], first_valid [2], last_valid [2];
    int nbeats [2];
    logic [W-1:0] last_beat [2];

    assign rd_empty[0] = (rd_idx[0] == wr_cnt);
    assign rd_empty[1] = (rd_idx[1] == wr_cnt);
    assign rd_data[0]  = pipe[0][1];
    assign rd_data[1]  = pipe[1][0];
    assign rd_size[0]  = SW'(wr_cnt - rd_idx[0]);
    assign rd_size[1]  = SW'(wr_cnt - rd_idx[1]);

    fifo_stream_reader #(.WIDTH(W), .ADDR_BITS(AB), .READ_LATENCY(2)) u_a (
        .clk(clk), .reset(reset),
        .fifo_rd_en(rd_en[0]), .fifo_rd_data(rd_data[0]), .fifo_rd_empty(rd_empty[0]),
        .fifo_rd_size(rd_size[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready), .out_data(out_data[0]),
        .words_sent(ws[0]), .rd_underflow_err(err[0])
    );

    fifo_stream_reader #(.WIDTH(W), .ADDR_BITS(AB), .READ_LATENCY(1)) u_b (
        .clk(clk), .reset(reset),
        .fifo_rd_en(rd_en[1]), .fifo_rd_data(rd_data[1]), .fifo_rd_empty(rd_empty[1]),
        .fifo_rd_size(rd_size[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready), .out_data(out_data[1]),
        .words_sent(ws[1]), .rd_underflow_err(err[1])
    );

    function automatic int lat(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    task automatic check(input string name, input int k, input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s rl%0d cyc %0d: got %0h expected %0h",
                      name, lat(k), cyc, got, exp);
    endtask

    task automatic write_word(input logic [W-1:0] w);
        if (wr_cnt < NWR) begin
            wr_words[wr_cnt] = w;
            wr_cnt++;
        end
    endtask

    task automatic clear_stats();
        for (int k = 0; k < 2; k++) begin
            nrden[k] = 0; first_rden[k] = 0; last_rden[k] = 0;
            nvalid[k] = 0; first_valid[k] = 0; last_valid[k] = 0;
            nbeats[k] = 0; last_beat[k] = '0;
        end
    endtask

    // One clock: compare at negedge, then advance the models just after posedge.
    task automatic step();
        logic [1:0] en_s;
        logic [1:0] hs_s;
        logic       rst_s;
        @(negedge clk);
        rst_s = reset;
        for (int k = 0; k < 2; k++) begin
            logic ev;
            logic er;
            ev = (tail[k] > head[k]) && (exp_av[k][head[k]] <= cyc);
            er = !reset && (rd_idx[k] < wr_cnt) && ((tail[k] - head[k]) < lat(k) + 2);
            check("out_valid", k, 32'(out_valid[k]), 32'(ev));
            if (ev) check("out_data", k, 32'(out_data[k]), 32'(exp_dat[k][head[k]]));
            check("fifo_rd_en", k, 32'(rd_en[k]), 32'(er));
            check("words_sent", k, ws[k], 32'(sent[k]));
            check("rd_underflow_err", k, 32'(err[k]), 32'd0);
            en_s[k] = rd_en[k];
            hs_s[k] = ev && out_ready && !rst_s;
            if (rd_en[k]) begin
                if (nrden[k] == 0) first_rden[k] = cyc;
                last_rden[k] = cyc;
                nrden[k]++;
            end
            if (out_valid[k]) begin
                if (nvalid[k] == 0) first_valid[k] = cyc;
                last_valid[k] = cyc;
                nvalid[k]++;
                if (out_ready && !rst_s) begin
                    nbeats[k]++;
                    last_beat[k] = out_data[k];
                end
            end
        end
        check("skid_overflow", 0, 32'(u_a.push_c && (u_a.count_q == 4)), 32'd0);
        check("skid_overflow", 1, 32'(u_b.push_c && (u_b.count_q == 3)), 32'd0);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            pipe[k][1] = pipe[k][0];
            pipe[k][0] = W'($urandom);
            if (rst_s) begin
                rd_idx[k] = wr_cnt;
                head[k]   = tail[k];
                sent[k]   = 0;
            end else begin
                if (en_s[k] && rd_idx[k] < wr_cnt) begin
                    pipe[k][0]         = wr_words[rd_idx[k]];
                    exp_dat[k][tail[k]] = wr_words[rd_idx[k]];
                    exp_av[k][tail[k]]  = cyc + lat(k) + 1;
                    rd_idx[k]++;
                    tail[k]++;
                end
                if (hs_s[k]) begin
                    head[k]++;
                    sent[k]++;
                end
            end
        end
        cyc++;
    endtask

    initial begin
        int  nwritten;
        bit  done;
        n_pass = 0; n_total = 0; cyc = 0; wr_cnt = 0;
        for (int k = 0; k < 2; k++) begin
            rd_idx[k] = 0; head[k] = 0; tail[k] = 0; sent[k] = 0;
            pipe[k][0] = '0; pipe[k][1] = '0;
        end
        clear_stats();
        reset = 1'b1;
        out_ready = 1'b0;
        repeat (3) step();
        for (int k = 0; k < 2; k++) begin
            check("reset_rd_en", k, 32'(rd_en[k]), 32'd0);
            check("reset_out_valid", k, 32'(out_valid[k]), 32'd0);
            check("reset_out_data", k, 32'(out_data[k]), 32'd0);
            check("reset_words_sent", k, ws[k], 32'd0);
            check("reset_err", k, 32'(err[k]), 32'd0);
        end
        reset = 1'b0;

        // Streaming at full rate
        clear_stats();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) write_word(W'(i));
        repeat (30) step();
        for (int k = 0; k < 2; k++) begin
            check("stream_latency", k, 32'(first_valid[k] - first_rden[k]), 32'(lat(k) + 1));
            check("stream_beats", k, 32'(nbeats[k]), 32'd16);
            check("stream_valid_run", k, 32'(last_valid[k] - first_valid[k]), 32'd15);
            check("stream_rden_run", k, 32'(last_rden[k] - first_rden[k]), 32'd15);
            check("stream_last_word", k, 32'(last_beat[k]), 32'h000F);
            check("stream_words_sent", k, ws[k], 32'd16);
        end

        // Backpressure
        clear_stats();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) write_word(W'(16'h0100 + i));
        repeat (20) step();
        for (int k = 0; k < 2; k++) begin
            check("bp_reads", k, 32'(nrden[k]), 32'(lat(k) + 2));
            check("bp_valid_held", k, 32'(out_valid[k]), 32'd1);
        end
        out_ready = 1'b1;
        repeat (20) step();
        for (int k = 0; k < 2; k++) begin
            check("bp_beats", k, 32'(nbeats[k]), 32'd10);
            check("bp_last_word", k, 32'(last_beat[k]), 32'h0109);
            check("bp_words_sent", k, ws[k], 32'd26);
        end

        // Single word
        clear_stats();
        write_word(16'hBEEF);
        repeat (10) step();
        for (int k = 0; k < 2; k++) begin
            check("single_reads", k, 32'(nrden[k]), 32'd1);
            check("single_beats", k, 32'(nbeats[k]), 32'd1);
            check("single_word", k, 32'(last_beat[k]), 32'hBEEF);
            check("single_idle", k, 32'(out_valid[k]), 32'd0);
        end

        // Reset with reads in flight and one word buffered
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) write_word(W'(16'h0200 + i));
        repeat (3) step();
        check("pre_reset_valid", 0, 32'(out_valid[0]), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            check("post_reset_valid", k, 32'(out_valid[k]), 32'd0);
            check("post_reset_words_sent", k, ws[k], 32'd0);
            check("post_reset_data", k, 32'(out_data[k]), 32'd0);
        end
        clear_stats();
        repeat (10) step();
        for (int k = 0; k < 2; k++) begin
            check("stale_never_valid", k, 32'(nvalid[k]), 32'd0);
            check("post_reset_reads", k, 32'(nrden[k]), 32'd0);
        end

        // Random traffic with random backpressure
        clear_stats();
        nwritten = 0;
        done = 1'b0;
        for (int c = 0; c < 20000 && !done; c++) begin
            if (nwritten < 1000 && (wr_cnt - rd_idx[0]) < 16 && (wr_cnt - rd_idx[1]) < 16
                && ($urandom % 4) != 0) begin
                write_word(W'($urandom));
                nwritten++;
            end
            out_ready = 1'($urandom % 2);
            step();
            done = (nwritten == 1000) && (head[0] == tail[0]) && (head[1] == tail[1])
                   && (rd_idx[0] == wr_cnt) && (rd_idx[1] == wr_cnt);
        end
        for (int k = 0; k < 2; k++) begin
            check("random_beats", k, 32'(nbeats[k]), 32'd1000);
            check("random_err", k, 32'(err[k]), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
